// File: rtl/bcd_results_display.sv
// bcd_results_display
// Latches the 16-bit round result {masterFlag, slaveFlag, scoreTens, scoreOnes}
// on a valid pulse and drives a 4-digit multiplexed common-anode 7-segment
// display. The sole winner's flag digit blinks.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   resultValid       one-cycle pulse, bcdResults16 valid this cycle
//   clearResult       drop the displayed result and return to idle
//   bcdResults16      [15:12] master flag, [11:8] slave flag, [7:4] tens, [3:0] ones
//   seg               active-low segments, [7]=dp, [6:0]=g..a
//   an                active-low digit enables, an[3]=leftmost
//   showing           high while a result (or no-result dashes) is displayed
module bcd_results_display #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resultValid,
  input  logic        clearResult,
  input  logic [15:0] bcdResults16,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        showing
);

  localparam int unsigned SCAN_W     = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W    = $clog2(BLINK_DIV);
  localparam int unsigned HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned SCAN_LAST  = SCAN_DIV - 1;
  localparam int unsigned BLINK_LAST = BLINK_DIV - 1;
  localparam int unsigned HOLD_LAST  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW     = 2'd1,
    NORESULT = 2'd2
  } stateT;

  stateT              state, stateNext;
  logic [15:0]        resultReg, resultNext;
  logic [SCAN_W-1:0]  scanCnt, scanCntNext;
  logic [1:0]         scanIdx, scanIdxNext;
  logic [BLINK_W-1:0] blinkCnt, blinkCntNext;
  logic               blinkOn, blinkOnNext;
  logic [HOLD_W-1:0]  holdCnt, holdCntNext;
  logic [7:0]         segNext;
  logic [3:0]         anNext;
  logic               showingNext;

  // Numeral glyphs 0..9, dp off; anything else renders as a dash
  function automatic logic [7:0] glyphOf(input logic [3:0] d);
    case (d)
      4'd0:    glyphOf = 8'hC0;
      4'd1:    glyphOf = 8'hF9;
      4'd2:    glyphOf = 8'hA4;
      4'd3:    glyphOf = 8'hB0;
      4'd4:    glyphOf = 8'h99;
      4'd5:    glyphOf = 8'h92;
      4'd6:    glyphOf = 8'h82;
      4'd7:    glyphOf = 8'hF8;
      4'd8:    glyphOf = 8'h80;
      4'd9:    glyphOf = 8'h90;
      default: glyphOf = GLYPH_DASH;
    endcase
  endfunction

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      resultReg <= '0;
      scanCnt   <= '0;
      scanIdx   <= '0;
      blinkCnt  <= '0;
      blinkOn   <= 1'b1;
      holdCnt   <= '0;
      seg       <= GLYPH_BLANK;
      an        <= 4'b1111;
      showing   <= 1'b0;
    end else begin
      state     <= stateNext;
      resultReg <= resultNext;
      scanCnt   <= scanCntNext;
      scanIdx   <= scanIdxNext;
      blinkCnt  <= blinkCntNext;
      blinkOn   <= blinkOnNext;
      holdCnt   <= holdCntNext;
      seg       <= segNext;
      an        <= anNext;
      showing   <= showingNext;
    end
  end

  // Next-state, counter updates and display decode
  always_comb begin
    logic [3:0] nib;
    logic       flagDigit;
    logic       soleWinner;

    stateNext    = state;
    resultNext   = resultReg;
    scanCntNext  = scanCnt;
    scanIdxNext  = scanIdx;
    blinkCntNext = blinkCnt;
    blinkOnNext  = blinkOn;
    holdCntNext  = holdCnt;
    segNext      = GLYPH_DASH;
    anNext       = ~(4'b0001 << scanIdx);
    nib          = resultReg[{scanIdx, 2'b00} +: 4];
    flagDigit    = scanIdx[1];
    soleWinner   = (resultReg[15:12] == 4'd1) ^ (resultReg[11:8] == 4'd1);

    // Digit scan free-runs regardless of state
    if (scanCnt == SCAN_W'(SCAN_LAST)) begin
      scanCntNext = '0;
      scanIdxNext = scanIdx + 2'd1;
    end else begin
      scanCntNext = scanCnt + SCAN_W'(1);
    end

    if (state == SHOW) begin
      if (blinkCnt == BLINK_W'(BLINK_LAST)) begin
        blinkCntNext = '0;
        blinkOnNext  = ~blinkOn;
      end else begin
        blinkCntNext = blinkCnt + BLINK_W'(1);
      end
    end

    // Auto-return to idle after the hold time, when enabled
    if ((HOLD_CYCLES > 0) && (state != IDLE)) begin
      if (holdCnt == HOLD_W'(HOLD_LAST)) begin
        stateNext = IDLE;
      end else begin
        holdCntNext = holdCnt + HOLD_W'(1);
      end
    end

    if (clearResult) begin
      stateNext = IDLE;
    end

    // A new result wins over clear and hold expiry
    if (resultValid) begin
      resultNext   = bcdResults16;
      blinkCntNext = '0;
      blinkOnNext  = 1'b1;
      holdCntNext  = '0;
      stateNext    = (bcdResults16 == 16'h0000) ? NORESULT : SHOW;
    end

    if (state == SHOW) begin
      if (flagDigit) begin
        segNext = (nib <= 4'd1) ? glyphOf(nib) : GLYPH_DASH;
        if (soleWinner && (nib == 4'd1) && !blinkOn) begin
          segNext = GLYPH_BLANK;
        end
      end else begin
        segNext = glyphOf(nib);
        // Leading-zero suppression on the tens digit
        if ((scanIdx == 2'd1) && (nib == 4'd0)) begin
          segNext = GLYPH_BLANK;
        end
      end
    end

    showingNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_bcd_results_display.sv
// tb_bcd_results_display
// Two instances share clk/rst: dutA holds results until cleared, dutB
// auto-returns to idle after 20 cycles. Stimulus pushes expected outputs
// keyed by cycle number into a scoreboard; a monitor on the falling edge
// pops and compares every entry due at that cycle.
module tb_bcd_results_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 8;
  localparam logic [31:0] IDLE_G = 32'hBFBFBFBF;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] seg;
    logic [3:0] an;
    logic       show;
    bit         chkSeg;
    string      tag;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        validA, clearA, validB, clearB;
  logic [15:0] wordA, wordB;
  logic [7:0]  segA, segB;
  logic [3:0]  anA, anB;
  logic        showA, showB;

  int   cyc = 0;
  int   scanBase = 0;
  int   nChecks = 0;
  int   nFail = 0;
  expT  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_results_display #(.SCAN_DIV(4), .BLINK_DIV(8), .HOLD_CYCLES(0)) dutA (
    .clk(clk), .rst(rst), .resultValid(validA), .clearResult(clearA),
    .bcdResults16(wordA), .seg(segA), .an(anA), .showing(showA)
  );

  bcd_results_display #(.SCAN_DIV(4), .BLINK_DIV(8), .HOLD_CYCLES(20)) dutB (
    .clk(clk), .rst(rst), .resultValid(validB), .clearResult(clearB),
    .bcdResults16(wordB), .seg(segB), .an(anB), .showing(showB)
  );

  task automatic pushFixed(input int d, input int c, input logic [7:0] s, input logic [3:0] a,
                           input logic sh, input bit chk, input string tag);
    expT e;
    e.cyc = c; e.dut = d; e.seg = s; e.an = a; e.show = sh; e.chkSeg = chk; e.tag = tag;
    sb.push_back(e);
  endtask

  // Expected display for cycles c0..c1: digit from the scan phase, glyph from
  // the hand-built table g = {d3,d2,d1,d0}, optional blink on one digit.
  task automatic pushRange(input int d, input int c0, input int c1, input logic [31:0] g,
                           input int blinkDig, input int evCyc, input logic sh, input string tag);
    for (int c = c0; c <= c1; c++) begin
      int  dig;
      expT e;
      dig = ((c - scanBase - 1) / SCAN) % 4;
      e.cyc = c; e.dut = d; e.show = sh; e.chkSeg = 1'b1; e.tag = tag;
      e.seg = g[dig*8 +: 8];
      if ((dig == blinkDig) && ((((c - evCyc - 1) / BLINK) % 2) == 1)) e.seg = 8'hFF;
      e.an = ~(4'b0001 << dig);
      sb.push_back(e);
    end
  endtask

  task automatic waitTo(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] aSeg;
    logic [3:0] aAn;
    logic       aShow;
    bit         ok;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        aSeg  = (sb[i].dut == 1) ? segB : segA;
        aAn   = (sb[i].dut == 1) ? anB : anA;
        aShow = (sb[i].dut == 1) ? showB : showA;
        ok = (sb[i].cyc == cyc) && (aShow === sb[i].show) &&
             (!sb[i].chkSeg || ((aSeg === sb[i].seg) && (aAn === sb[i].an)));
        nChecks++;
        if (!ok) begin
          nFail++;
          $display("FAIL %s dut%0d cyc %0d (due %0d): seg=%h an=%b showing=%b, expected seg=%h an=%b showing=%b",
                   sb[i].tag, sb[i].dut, cyc, sb[i].cyc, aSeg, aAn, aShow,
                   sb[i].seg, sb[i].an, sb[i].show);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1;
    validA = 1'b0; clearA = 1'b0; wordA = '0;
    validB = 1'b0; clearB = 1'b0; wordB = '0;
    for (int c = 1; c <= 3; c++) begin
      pushFixed(0, c, 8'hFF, 4'b1111, 1'b0, 1'b1, "reset");
      pushFixed(1, c, 8'hFF, 4'b1111, 1'b0, 1'b1, "reset");
    end
    waitTo(3);
    rst = 1'b0;
    scanBase = 3;
    pushRange(0, 4, 25, IDLE_G, -1, 0, 1'b0, "idle-scan");
    pushRange(1, 4, 11, IDLE_G, -1, 0, 1'b0, "idle-scan");

    // Master win, master flag blinks
    waitTo(25);
    validA = 1'b1; wordA = 16'h1021;
    pushFixed(0, 26, 8'h00, 4'h0, 1'b1, 1'b0, "win-showing");
    pushRange(0, 27, 74, 32'hF9C0A4F9, 3, 26, 1'b1, "win");
    waitTo(26);
    validA = 1'b0;

    // Draw: no blink, even across blinkOn low phases
    waitTo(86);
    validA = 1'b1; wordA = 16'h1120;
    pushRange(0, 88, 119, 32'hF9F9A4C0, -1, 87, 1'b1, "draw");
    waitTo(87);
    validA = 1'b0;

    // Leading-zero suppression
    waitTo(119);
    validA = 1'b1; wordA = 16'h0009;
    pushRange(0, 121, 136, 32'hC0C0FF90, -1, 120, 1'b1, "lead-zero");
    waitTo(120);
    validA = 1'b0;

    // No result
    waitTo(136);
    validA = 1'b1; wordA = 16'h0000;
    pushFixed(0, 137, 8'h00, 4'h0, 1'b1, 1'b0, "noresult-showing");
    pushRange(0, 138, 153, IDLE_G, -1, 137, 1'b1, "noresult");
    waitTo(137);
    validA = 1'b0;

    // Illegal score digits, slave flag blinks
    waitTo(161);
    validA = 1'b1; wordA = 16'h01AB;
    pushRange(0, 163, 194, 32'hC0F9BFBF, 2, 162, 1'b1, "illegal");
    waitTo(162);
    validA = 1'b0;

    // Clear alone
    waitTo(194);
    clearA = 1'b1;
    pushFixed(0, 195, 8'h00, 4'h0, 1'b0, 1'b0, "clear-showing");
    pushRange(0, 196, 203, IDLE_G, -1, 0, 1'b0, "clear-idle");
    waitTo(195);
    clearA = 1'b0;

    // Clear and valid together: valid wins
    waitTo(203);
    clearA = 1'b1; validA = 1'b1; wordA = 16'h0121;
    pushFixed(0, 204, 8'h00, 4'h0, 1'b1, 1'b0, "prio-showing");
    pushRange(0, 205, 220, 32'hC0F9A4F9, 2, 204, 1'b1, "prio");
    waitTo(204);
    clearA = 1'b0; validA = 1'b0;

    // Hold timeout: showing exactly 20 cycles (221..240)
    waitTo(220);
    validB = 1'b1; wordB = 16'h0120;
    pushRange(1, 221, 221, IDLE_G, -1, 0, 1'b1, "hold-start");
    pushRange(1, 222, 240, 32'hC0F9A4C0, 2, 221, 1'b1, "hold");
    pushRange(1, 241, 241, 32'hC0F9A4C0, 2, 221, 1'b0, "hold-expire");
    pushRange(1, 242, 249, IDLE_G, -1, 0, 1'b0, "hold-idle");
    waitTo(221);
    validB = 1'b0;

    // Retrigger then reset mid-display
    waitTo(249);
    validB = 1'b1;
    waitTo(250);
    validB = 1'b0;
    waitTo(254);
    rst = 1'b1;
    pushFixed(0, 255, 8'hFF, 4'b1111, 1'b0, 1'b1, "reset-mid");
    pushFixed(1, 255, 8'hFF, 4'b1111, 1'b0, 1'b1, "reset-mid");
    scanBase = 255;
    pushRange(0, 256, 259, IDLE_G, -1, 0, 1'b0, "post-reset");
    pushRange(1, 256, 259, IDLE_G, -1, 0, 1'b0, "post-reset");
    waitTo(255);
    rst = 1'b0;

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      nChecks++;
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/bcd_results_display.md
Name: bcd_results_display

Overview:
Consumer of the 16-bit game result word {masterState, slaveState, scoreTen, scoreOne} produced when a round finishes. Latches the word on a valid pulse and drives a 4-digit time-multiplexed common-anode 7-segment display. The winner's flag digit blinks. Sits between the result encoder and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (scan period = 4*SCAN_DIV); must be >= 2
BLINK_DIV, 25000000, clock cycles per blink half-period; must be >= 2
HOLD_CYCLES, 0, cycles a result stays shown before auto-return to idle; 0 = hold until clearResult

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
resultValid  input  1  one-cycle pulse: bcdResults16 valid this cycle
clearResult  input  1  level/pulse: drop displayed result, return to idle
bcdResults16  input  16  [15:12] master flag, [11:8] slave flag, [7:4] score tens, [3:0] score ones
seg  output  8  segment drive, active-low, [7]=dp, [6:0]=g..a
an  output  4  digit enable, active-low, an[3]=leftmost
showing  output  1  high while in SHOW or NORESULT

Behaviour:
- Reset (rst=1 at edge): state=IDLE, resultReg=0, scanCnt=0, scanIdx=0, blinkCnt=0, blinkOn=1, holdCnt=0; outputs seg=8'hFF, an=4'b1111, showing=0.
- States: IDLE, SHOW, NORESULT.
- resultValid=1 in any state: next edge latches bcdResults16 into resultReg and clears blinkCnt/holdCnt; blinkOn=1. Next state is NORESULT if the word is 16'h0000, else SHOW. A retrigger while showing is allowed.
- clearResult=1 and resultValid=0: next state IDLE, resultReg unchanged. resultValid has priority when both are high.
- HOLD_CYCLES>0: holdCnt increments each cycle in SHOW/NORESULT. When holdCnt==HOLD_CYCLES-1, next state is IDLE.
- Scan: scanCnt counts 0..SCAN_DIV-1 and wraps. On wrap, scanIdx increments mod 4. scanIdx free-runs in every state and is not reset by resultValid.
- Outputs are registered, one cycle after scanIdx/state: an = ~(1<<scanIdx); seg = glyph of selected digit.
- Digit map: scanIdx 3 = master flag, 2 = slave flag, 1 = tens, 0 = ones.
- Glyphs (dp off, bit7=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90; dash=BF; blank=FF.
- IDLE: all four digits show dash.
- NORESULT: all four digits show dash; showing=1.
- SHOW, digit glyphs:
  - Flag digits: nibble 0 or 1 shows numeral; nibble >1 shows dash.
  - Score digits: nibble 0..9 shows numeral; >9 shows dash.
  - Tens==0: tens digit shows blank (leading-zero suppression).
- Blink: blinkCnt counts 0..BLINK_DIV-1 in SHOW only; on wrap blinkOn toggles.
  - Exactly one flag nibble ==1: that flag digit shows blank while blinkOn=0.
  - Both flags 1 (draw) or neither: no blink.
  - Score digits never blink.
- showing=1 iff state is SHOW or NORESULT (registered with state).
- Reset mid-display: returns to IDLE within one edge, outputs reset values that cycle.

Test Plan:
- Reset: rst high 3 cycles -> seg=FF, an=1111, showing=0; after release with SCAN_DIV=4, an cycles 1110,1101,1011,0111 every 4 cycles, seg=BF on each.
- Master win: pulse resultValid with 16'h1021, BLINK_DIV=8 -> showing=1; digits 3..0 = F9,C0,A4,F9; digit3 alternates F9/FF every 8 cycles, other digits steady.
- Draw/leading zero: 16'h1120 -> F9,F9,A4,C0, no blink. Word 16'h0009 -> digit1 = FF, digit0 = 90.
- No result and illegal digits: 16'h0000 -> NORESULT, all BF, showing=1. 16'h01AB -> digits 1,0 = BF.
- Clear/priority: clearResult alone -> IDLE next edge, showing=0. clearResult+resultValid(16'h0121) same cycle -> SHOW with new word.
- Hold timeout: HOLD_CYCLES=20, valid 16'h0120 -> showing high exactly 20 cycles, then IDLE dashes; rst asserted mid-SHOW -> outputs FF/1111 next edge.
